// File: rtl/dco_sdm_pkg.sv
// Shared constants and encodings for the DCO sigma-delta controller.
package dco_sdm_pkg;

   localparam int INT_W_DEF  = 8;
   localparam int FRAC_W_DEF = 8;

   // Modulator order selection as presented on sdm_order.
   typedef enum logic [1:0] {
      ORD_BYP = 2'd0,
      ORD_1   = 2'd1,
      ORD_2   = 2'd2,
      ORD_3   = 2'd3
   } sdm_order_e;

   // Mid-scale DCO code, used as the reset value.
   localparam int DCO_MID = 128;

   // Width of the signed MASH output y (range -3..+4).
   localparam int Y_W = 4;

endpackage

// File: rtl/mash_acc_stage.sv
// One MASH accumulator: FRAC_W-bit wrap-around adder with carry-out.
// When the stage is disabled or cleared, the accumulator is reloaded with 0
// and both the sum and the carry are forced to 0.
module mash_acc_stage #(
   parameter int FRAC_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic [FRAC_W-1:0] din,
   output logic [FRAC_W-1:0] sum,
   output logic              carry
);

   logic [FRAC_W-1:0] acc;
   logic [FRAC_W:0]   add_w;

   // Add input to accumulator; gate the sum and carry when inactive.
   always_comb begin
      add_w = {1'b0, acc} + {1'b0, din};
      sum   = '0;
      carry = 1'b0;
      if (en && !clr) begin
         sum   = add_w[FRAC_W-1:0];
         carry = add_w[FRAC_W];
      end
   end

   // Accumulator register; the gated sum is already 0 when inactive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) acc <= '0;
      else     acc <= sum;
   end

endmodule

// File: rtl/dco_sdm_ctrl.sv
// Loop-filter word to DCO tuning code: integer part drives the bank directly,
// fractional part is dithered by a selectable MASH 1-1-1 modulator, and the
// stage-1 residue is returned as the noise-cancellation word.
import dco_sdm_pkg::*;

module dco_sdm_ctrl #(
   parameter int INT_W    = INT_W_DEF,
   parameter int FRAC_W   = FRAC_W_DEF,
   parameter int NC_SHIFT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [1:0]       sdm_order,
   input  logic             dlf_stb,
   input  logic [15:0]      dlf_word,
   output logic             dlf_ack,
   output logic [INT_W-1:0] dco_code,
   output logic             sdm_sat,
   output logic [14:0]      sdm_nc_out
);

   logic signed [15:0]      word_q;
   logic [1:0]              order_q;
   logic [INT_W-1:0]        int_u;
   logic [FRAC_W-1:0]       frac;
   logic                    clr;
   logic                    en1, en2, en3;
   logic [FRAC_W-1:0]       n1, n2, n3;
   logic                    c1, c2, c3;
   logic                    c2_d, c3_d, c3_dd;
   logic [Y_W-1:0]          y_u;
   logic signed [Y_W-1:0]   y;
   logic [INT_W:0]          sat_res;
   logic [14:0]             nc_w;

   // Saturating add of the signed dither onto the unsigned integer code.
   // Result is {clamp_flag, code}; the sum is formed on INT_W+2 bits.
   function automatic logic [INT_W:0] sat_add(input logic [INT_W-1:0] base,
                                              input logic signed [Y_W-1:0] d);
      logic signed [INT_W+1:0] s;
      s = $signed({2'b00, base}) + $signed({{(INT_W+2-Y_W){d[Y_W-1]}}, d});
      if (s[INT_W+1])  return {1'b1, {INT_W{1'b0}}};
      else if (s[INT_W]) return {1'b1, {INT_W{1'b1}}};
      else             return {1'b0, s[INT_W-1:0]};
   endfunction

   // Split the captured word; flipping the sign bit gives the offset-binary code.
   always_comb begin
      int_u = {~word_q[15], word_q[14:FRAC_W]};
      frac  = word_q[FRAC_W-1:0];
   end

   // Clear the modulator when disabled, bypassed, or the order just changed.
   always_comb begin
      clr = !enable || (sdm_order != order_q) || (sdm_order == ORD_BYP);
      en1 = (sdm_order != ORD_BYP);
      en2 = sdm_order[1];
      en3 = (sdm_order == ORD_3);
   end

   mash_acc_stage #(.FRAC_W(FRAC_W)) u_stage1 (
      .clk(clk), .rst(rst), .en(en1), .clr(clr), .din(frac), .sum(n1), .carry(c1)
   );
   mash_acc_stage #(.FRAC_W(FRAC_W)) u_stage2 (
      .clk(clk), .rst(rst), .en(en2), .clr(clr), .din(n1), .sum(n2), .carry(c2)
   );
   mash_acc_stage #(.FRAC_W(FRAC_W)) u_stage3 (
      .clk(clk), .rst(rst), .en(en3), .clr(clr), .din(n2), .sum(n3), .carry(c3)
   );

   // MASH combiner: c1 + (1-z^-1)c2 + (1-z^-1)^2 c3, forced to 0 on clear.
   always_comb begin
      y_u = Y_W'(c1) + Y_W'(c2) - Y_W'(c2_d)
          + Y_W'(c3) - (Y_W'(c3_d) << 1) + Y_W'(c3_dd);
      y   = clr ? '0 : $signed(y_u);
      sat_res = sat_add(int_u, y);
      nc_w = 15'(n1) << NC_SHIFT;
   end

   // Capture, carry delays, order history and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q     <= '0;
         dlf_ack    <= 1'b0;
         order_q    <= ORD_BYP;
         c2_d       <= 1'b0;
         c3_d       <= 1'b0;
         c3_dd      <= 1'b0;
         dco_code   <= INT_W'(DCO_MID);
         sdm_sat    <= 1'b0;
         sdm_nc_out <= '0;
      end else begin
         if (dlf_stb) word_q <= dlf_word;
         dlf_ack    <= dlf_stb;
         order_q    <= sdm_order;
         c2_d       <= clr ? 1'b0 : c2;
         c3_d       <= clr ? 1'b0 : c3;
         c3_dd      <= clr ? 1'b0 : c3_d;
         dco_code   <= sat_res[INT_W-1:0];
         sdm_sat    <= sat_res[INT_W];
         sdm_nc_out <= nc_w;
      end
   end

   // n3 is the final residue; only the carry of stage 3 feeds the combiner.
   logic unused_n3;
   assign unused_n3 = ^n3;

endmodule

// File: tb/tb_dco_sdm_ctrl.sv
// Self-checking bench for dco_sdm_ctrl against an arithmetic reference model.
module tb_dco_sdm_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [1:0]  sdm_order;
   logic        dlf_stb;
   logic [15:0] dlf_word;
   logic        dlf_ack;
   logic [7:0]  dco_code;
   logic        sdm_sat;
   logic [14:0] sdm_nc_out;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   logic [15:0] m_word;
   int m_s1, m_s2, m_s3, m_c2d, m_c3d, m_c3dd, m_prev;
   int m_dco, m_sat, m_nc, m_ack;

   dco_sdm_ctrl dut (
      .clk(clk), .rst(rst), .enable(enable), .sdm_order(sdm_order),
      .dlf_stb(dlf_stb), .dlf_word(dlf_word), .dlf_ack(dlf_ack),
      .dco_code(dco_code), .sdm_sat(sdm_sat), .sdm_nc_out(sdm_nc_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_word = 16'h0000;
      m_s1 = 0; m_s2 = 0; m_s3 = 0;
      m_c2d = 0; m_c3d = 0; m_c3dd = 0; m_prev = 0;
      m_dco = 128; m_sat = 0; m_nc = 0; m_ack = 0;
   endfunction

   // One clock of the modulator, computed from the behavioural rules.
   function automatic void model_edge();
      int iu, fr, ord, t, c1, c2, c3, n1, n2, n3, y, v;
      bit clr;
      iu  = (int'(m_word[15:8]) + 128) % 256;
      fr  = int'(m_word[7:0]);
      ord = int'(sdm_order);
      clr = !enable || (ord != m_prev) || (ord == 0);
      c1 = 0; c2 = 0; c3 = 0; n1 = 0; n2 = 0; n3 = 0; y = 0;
      if (!clr) begin
         t = m_s1 + fr; c1 = t / 256; n1 = t % 256;
         if (ord >= 2) begin t = m_s2 + n1; c2 = t / 256; n2 = t % 256; end
         if (ord == 3) begin t = m_s3 + n2; c3 = t / 256; n3 = t % 256; end
         y = c1 + (c2 - m_c2d) + (c3 - 2 * m_c3d + m_c3dd);
      end
      v = iu + y;
      m_sat = (v < 0 || v > 255) ? 1 : 0;
      m_dco = (v < 0) ? 0 : (v > 255) ? 255 : v;
      m_nc  = n1 * 16;
      m_s1 = n1; m_s2 = n2; m_s3 = n3;
      m_c3dd = clr ? 0 : m_c3d;
      m_c3d  = clr ? 0 : c3;
      m_c2d  = clr ? 0 : c2;
      m_prev = ord;
      m_ack  = dlf_stb ? 1 : 0;
      if (dlf_stb) m_word = dlf_word;
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("dco_code", 32'(dco_code), 32'(m_dco));
      chk("sdm_sat", 32'(sdm_sat), 32'(m_sat));
      chk("sdm_nc_out", 32'(sdm_nc_out), 32'(m_nc));
      chk("dlf_ack", 32'(dlf_ack), 32'(m_ack));
   endtask

   task automatic strobe(input logic [15:0] w);
      dlf_word = w; dlf_stb = 1'b1;
      step();
      dlf_stb = 1'b0;
   endtask

   initial begin
      int sum, ymin, ymax, d, n;
      rst = 1'b1; enable = 1'b0; sdm_order = 2'd0; dlf_stb = 1'b0; dlf_word = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_dco", 32'(dco_code), 32'd128);
      chk("reset_sat", 32'(sdm_sat), 32'd0);
      chk("reset_nc", 32'(sdm_nc_out), 32'd0);
      chk("reset_ack", 32'(dlf_ack), 32'd0);
      repeat (3) step();

      // Order 1, 0x0540: carry every fourth cycle
      enable = 1'b1; sdm_order = 2'd1;
      strobe(16'h0540);
      chk("ack_after_strobe", 32'(dlf_ack), 32'd1);
      repeat (12) step();

      // Asynchronous reset on a cycle whose registered output carries
      n = 0;
      while (m_dco != 134 && n < 8) begin step(); n++; end
      chk("carry_cycle_found", 32'(dco_code), 32'd134);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_dco", 32'(dco_code), 32'd128);
      chk("async_rst_ack", 32'(dlf_ack), 32'd0);
      chk("async_rst_nc", 32'(sdm_nc_out), 32'd0);
      model_reset();
      @(negedge clk) rst = 1'b0;
      repeat (2) step();

      // Order 3, 0x0080: mean of 0.5 LSB, y within -3..+4
      sdm_order = 2'd3;
      strobe(16'h0080);
      repeat (8) step();
      sum = 0; ymin = 100; ymax = -100;
      for (int i = 0; i < 1024; i++) begin
         step();
         d = int'(dco_code) - 128;
         sum += d;
         if (d < ymin) ymin = d;
         if (d > ymax) ymax = d;
      end
      chk("mean_half", 32'((sum >= 511 && sum <= 513) ? 1 : 0), 32'd1);
      chk("y_range", 32'((ymin >= -3 && ymax <= 4) ? 1 : 0), 32'd1);

      // Saturation at both ends of the code range
      strobe(16'h7FFF);
      repeat (40) step();
      strobe(16'h8000);
      repeat (40) step();

      // Order 0, 0x03FF, then switch to order 2
      sdm_order = 2'd0;
      strobe(16'h03FF);
      repeat (4) step();
      chk("bypass_dco", 32'(dco_code), 32'd131);
      chk("bypass_nc", 32'(sdm_nc_out), 32'd0);
      sdm_order = 2'd2;
      step();
      chk("ord2_clear_nc", 32'(sdm_nc_out), 32'd0);
      step();
      chk("ord2_start_nc", 32'(sdm_nc_out), 32'h0FF0);
      repeat (10) step();

      // Enable dropped for 3 cycles with a strobe during the gap
      sdm_order = 2'd1;
      strobe(16'h1234);
      repeat (6) step();
      enable = 1'b0;
      step();
      strobe(16'h2260);
      step();
      enable = 1'b1;
      repeat (10) step();

      // Randomised phase
      for (int i = 0; i < 3000; i++) begin
         dlf_stb = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 9))
            0: dlf_word = 16'h7FFF;
            1: dlf_word = 16'h8000;
            default: dlf_word = 16'($urandom());
         endcase
         if ($urandom_range(0, 60) == 0) enable = ~enable;
         if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
         if ($urandom_range(0, 80) == 0) sdm_order = 2'($urandom_range(0, 3));
         step();
      end
      dlf_stb = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dco_sdm_ctrl.md
Name: dco_sdm_ctrl

Overview:
Consumes the 16-bit signed loop-filter word and converts it to a DCO tuning code.
- The integer part drives the DCO bank directly.
- The fractional part is dithered by a runtime-selectable MASH 1-1-1 sigma-delta modulator.
- The first-stage accumulator residue is returned as the 15-bit noise-cancellation word, subtracted from the decimator output ahead of the loop filter.
- Sits between the loop-filter output and the DCO; runs on the DCO/SDM clock, with sample strobes from the loop-filter clock domain already synchronous to it.

Parameters:
INT_W, 8, integer bits of the loop-filter word (upper bits), also DCO code width
FRAC_W, 8, fractional bits of the loop-filter word (lower bits); INT_W+FRAC_W = 16
NC_SHIFT, 4, left shift applied to the stage-1 residue to form sdm_nc_out; FRAC_W+NC_SHIFT <= 15

Ports:
clk  input  1  SDM clock
rst  input  1  reset, asynchronous, active-high
enable  input  1  SDM enable (already synchronised)
sdm_order  input  2  0 bypass, 1 first order, 2 MASH 1-1, 3 MASH 1-1-1
dlf_stb  input  1  one-cycle pulse: dlf_word valid
dlf_word  input  16  signed loop-filter output
dlf_ack  output  1  one-cycle pulse: sample captured
dco_code  output  INT_W  unsigned DCO tuning code
sdm_sat  output  1  dco_code clamped this cycle
sdm_nc_out  output  15  unsigned noise-cancellation word to the loop filter

Behaviour:
Interface decision: one clock; reset is asynchronous and active-high (clk, rst).

Reset values:
- word_q = 0
- accumulators s1/s2/s3 = 0
- carry delay registers = 0
- dco_code = 128 (mid-code for INT_W=8)
- sdm_sat = 0, sdm_nc_out = 0, dlf_ack = 0

Capture:
- dlf_stb high: dlf_word is registered into word_q; dlf_ack pulses the next cycle.
- dlf_stb is accepted on any cycle, including back-to-back; the last strobe wins.
- int_u = word_q[15:8] + 128 (sign-bit flip, unsigned); frac = word_q[7:0] unsigned.

MASH, per cycle with enable=1:
- Stage 1: {c1,n1} = s1 + frac.
- Stage 2: {c2,n2} = s2 + n1.
- Stage 3: {c3,n3} = s3 + n2. All FRAC_W-bit adds with carry; s_k <= n_k.
- Unused stages (by order) hold 0 and force their carry to 0.
- y = c1 + (c2 - c2_d) + (c3 - 2*c3_d + c3_dd), signed 4-bit, range -3..+4; _d / _dd are registered carry delays.
- Order 0: y = 0, all accumulators held at 0.

Output:
- dco_code <= sat(int_u + y), clamped to 0..2^INT_W-1.
- sdm_sat <= 1 on any cycle where the clamp is active.
- sdm_nc_out <= {zeros, s1_next << NC_SHIFT}, updated every cycle.

Latency:
- dlf_stb to new integer part visible on dco_code: 2 cycles.
- The frac change affects the adders 1 cycle after the strobe; its y appears 2 cycles after the strobe.

enable = 0:
- Accumulators and carry delays are cleared synchronously; y = 0.
- dco_code keeps tracking int_u; sdm_nc_out = 0.
- Capture and dlf_ack still operate.

sdm_order change (sampled each cycle):
- Any change versus the previous cycle clears s1..s3 and the carry delays on that cycle; y = 0 that cycle.

rst asserted mid-operation: all state returns to reset values immediately; no pending dlf_ack is emitted.

Arithmetic is unsigned for accumulators and signed for y. The saturated add uses INT_W+2 bits internally.

Decomposition:
Package dco_sdm_pkg:
- INT_W/FRAC_W defaults
- order encodings ORD_BYP / ORD_1 / ORD_2 / ORD_3
- DCO_MID = 128
- y width constant

Sub-module mash_acc_stage (FRAC_W-bit accumulator with carry-out, stage enable, and synchronous clear), instantiated three times. Combiner, saturation and capture stay in the top level.

Test Plan:
- Reset: hold rst, then release with no strobe -> dco_code = 128, sdm_sat = 0, sdm_nc_out = 0, dlf_ack = 0.
- Order 1, dlf_word = 0x0540 strobed -> dlf_ack 1 cycle later; dco_code settles to repeating 133,133,133,134 (carry every 4th cycle); sdm_nc_out cycles 0x400, 0x800, 0xC00, 0x000.
- Order 3, dlf_word = 0x0080 held 1024 cycles -> mean of dco_code - 128 = 0.5 (±1/1024); every y within -3..+4.
- Order 3, dlf_word = 0x7FFF -> dco_code never exceeds 255; sdm_sat pulses on the cycles where y > 0. dlf_word = 0x8000 -> dco_code never below 0; sdm_sat pulses where y < 0.
- Order 0, dlf_word = 0x03FF -> dco_code constant 131; sdm_nc_out = 0. Then switch to order 2 -> accumulators cleared that cycle; dithering starts the next cycle.
- enable dropped for 3 cycles mid-run, with a new dlf_stb during it -> dlf_ack still pulses; dco_code = int_u with no dither. Re-enable -> sequence restarts from s1 = 0. Assert rst during a carry cycle -> dco_code = 128 asynchronously.
